// File: rtl/keystream_word_unpacker_if.sv
// Keystream unpacker bus: core-side block request/return plus
// consumer-side valid/ready word stream.
interface keystream_word_unpacker_if #(
    parameter int WORD_W = 32
) ();
    logic              blk_req;
    logic [511:0]      blk_data;
    logic              blk_valid;
    logic [WORD_W-1:0] rnd_data;
    logic              rnd_valid;
    logic              rnd_ready;

    modport master (
        output blk_req,
        output rnd_data,
        output rnd_valid,
        input  blk_data,
        input  blk_valid,
        input  rnd_ready
    );

    modport slave (
        input  blk_req,
        input  rnd_data,
        input  rnd_valid,
        output blk_data,
        output blk_valid,
        output rnd_ready
    );
endinterface

// File: rtl/keystream_word_unpacker.sv
// Ping-pong buffer turning 512-bit ChaCha blocks into WORD_W-bit words.
// Optional RNG_REPEAT_CHECK_EN: discard a block identical to the last one.
module keystream_word_unpacker #(
    parameter int WORD_W = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    keystream_word_unpacker_if.master bus,
    output logic [1:0] fill_level_o,
`ifdef RNG_REPEAT_CHECK_EN
    output logic       rep_err_o,
`endif
    output logic       ovf_o
);
    localparam int NWORDS = 512 / WORD_W;
    localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    generate
        if (WORD_W < 8 || WORD_W > 512 || (512 % WORD_W) != 0 ||
            (WORD_W & (WORD_W - 1)) != 0) begin : g_bad_width
            $error("WORD_W must be a power of two between 8 and 512");
        end
    endgenerate

    typedef enum logic {
        REQ_IDLE,
        REQ_WAIT
    } req_e;

    req_e          state_q, state_d;
    logic          blk_req_q, blk_req_d;
    logic [1:0]    fill_q, fill_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ovf_q, ovf_d;
    logic [511:0]  slot_q [2];

    logic          rnd_valid;
    logic          hs;
    logic          last;
    logic          space;
    logic          rep_hit;
    logic          wr_en;

`ifdef RNG_REPEAT_CHECK_EN
    logic [511:0]  prev_q;
    logic          has_prev_q;
    logic          rep_q, rep_d;

    assign rep_hit   = has_prev_q && (bus.blk_data == prev_q);
    assign rep_err_o = rep_q;
`else
    assign rep_hit   = 1'b0;
`endif

    assign rnd_valid     = (fill_q != 2'd0);
    assign hs            = rnd_valid && bus.rnd_ready;
    assign last          = hs && (idx_q == IW'(NWORDS - 1));
    // A slot whose last word leaves this cycle is free for the arriving block.
    assign space         = (fill_q != 2'd2) || last;
    assign wr_en         = bus.blk_valid && space && !rep_hit;

    assign bus.blk_req   = blk_req_q;
    assign bus.rnd_valid = rnd_valid;
    assign bus.rnd_data  = slot_q[rd_q][WORD_W*idx_q +: WORD_W];
    assign fill_level_o  = fill_q;
    assign ovf_o         = ovf_q;

    // Datapath next state: read pointer, word index, fill count, flags.
    always_comb begin
        idx_d  = idx_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        fill_d = fill_q;
        ovf_d  = ovf_q;
`ifdef RNG_REPEAT_CHECK_EN
        rep_d  = rep_q;
`endif

        if (hs) begin
            if (last) begin
                idx_d = '0;
                rd_d  = ~rd_q;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end

        if (bus.blk_valid) begin
            if (rep_hit) begin
`ifdef RNG_REPEAT_CHECK_EN
                rep_d = 1'b1;
`endif
            end else if (!space) begin
                ovf_d = 1'b1;
            end
        end

        if (wr_en) begin
            wr_d = ~wr_q;
        end

        if (wr_en && !last) begin
            fill_d = fill_q + 2'd1;
        end else if (!wr_en && last) begin
            fill_d = fill_q - 2'd1;
        end
    end

    // Request FSM: one block outstanding, gated on post-update occupancy.
    always_comb begin
        state_d   = state_q;
        blk_req_d = 1'b0;

        unique case (state_q)
            REQ_IDLE: begin
                if (enable_i && fill_d != 2'd2) begin
                    blk_req_d = 1'b1;
                    state_d   = REQ_WAIT;
                end
            end
            REQ_WAIT: begin
                if (bus.blk_valid) begin
                    state_d = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= REQ_IDLE;
            blk_req_q <= 1'b0;
            fill_q    <= 2'd0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            blk_req_q <= blk_req_d;
            fill_q    <= fill_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            if (wr_en) begin
                slot_q[wr_q] <= bus.blk_data;
            end
        end
    end

`ifdef RNG_REPEAT_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q     <= '0;
            has_prev_q <= 1'b0;
            rep_q      <= 1'b0;
        end else begin
            rep_q <= rep_d;
            if (wr_en) begin
                prev_q     <= bus.blk_data;
                has_prev_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_keystream_word_unpacker.sv
// Directed bench for keystream_word_unpacker: core latency model,
// vector table on the streamed words, hand sequences for corner cases.
module tb_keystream_word_unpacker;
    localparam int LAT = 20;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic [1:0] fill;
    logic ovf;
`ifdef RNG_REPEAT_CHECK_EN
    logic rep_err;
`endif

    always #5 clk = ~clk;

    keystream_word_unpacker_if #(.WORD_W(32)) bus ();

    keystream_word_unpacker #(.WORD_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .bus         (bus),
        .fill_level_o(fill),
`ifdef RNG_REPEAT_CHECK_EN
        .rep_err_o   (rep_err),
`endif
        .ovf_o       (ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Block k, word j = C0DE_kkjj (k in bits 15:8, j in bits 7:0).
    function automatic logic [511:0] blkgen(input int k);
        logic [511:0] b;
        b = '0;
        for (int j = 0; j < 16; j++) begin
            b[32*j +: 32] = 32'hC0DE0000 | 32'(k * 256 + j);
        end
        return b;
    endfunction

    // Core model: answers each blk_req after LAT cycles with the next block.
    bit core_on = 1'b0;
    int cnt = 0;
    int bnext = 0;

    always @(negedge clk) begin
        if (rst) begin
            cnt   = 0;
            bnext = 0;
            if (core_on) bus.blk_valid = 1'b0;
        end else if (core_on) begin
            bus.blk_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.blk_valid = 1'b1;
                    bus.blk_data  = blkgen(bnext);
                    bnext++;
                end
            end else if (bus.blk_req) begin
                cnt = LAT;
            end
        end
    end

    int  cyc = 0;
    int  last_bv = -100;
    int  reqs = 0;
    bit  prev_req = 1'b0;
    bit  consec = 1'b0;

    always @(posedge clk) begin
        if (bus.blk_req) begin
            reqs++;
            if (prev_req) consec = 1'b1;
        end
        prev_req = bus.blk_req;
        if (bus.blk_valid) last_bv = cyc;
        cyc++;
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.rnd_ready = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        core_on = 1'b0;
        bus.blk_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic inject(input int k);
        bus.blk_valid = 1'b1;
        bus.blk_data  = blkgen(k);
        @(negedge clk);
        bus.blk_valid = 1'b0;
    endtask

    task automatic take(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rnd_ready = 1'b1;
            @(negedge clk);
        end
        bus.rnd_ready = 1'b0;
    endtask

    typedef struct {
        int          n;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [6];
    logic [31:0] got [48];
    int          ngot;
    int          c32;
    int          k;
    int          r0;
    bit          unstable;
    bit          seen;

    initial begin
        tbl[0] = '{0,  32'hC0DE0000};
        tbl[1] = '{15, 32'hC0DE000F};
        tbl[2] = '{16, 32'hC0DE0100};
        tbl[3] = '{31, 32'hC0DE010F};
        tbl[4] = '{32, 32'hC0DE0200};
        tbl[5] = '{47, 32'hC0DE020F};

        rst = 1'b1;
        enable = 1'b0;
        bus.blk_valid = 1'b0;
        bus.blk_data = '0;
        bus.rnd_ready = 1'b0;
        @(negedge clk);
        do_reset();

        chk("rst_valid", bus.rnd_valid, 0);
        chk("rst_data", bus.rnd_data, 0);
        chk("rst_fill", fill, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_req", bus.blk_req, 0);

        // First block latency, then 100 cycles with consumer stalled.
        core_on = 1'b1;
        enable = 1'b1;
        k = 0;
        seen = 1'b0;
        unstable = 1'b0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (bus.rnd_valid && !seen) begin
                seen = 1'b1;
                chk("lat_cycles", 64'(cyc - last_bv), 1);
                chk("lat_data", bus.rnd_data, 32'hC0DE0000);
            end else if (seen) begin
                if (!bus.rnd_valid || bus.rnd_data !== 32'hC0DE0000)
                    unstable = 1'b1;
            end
        end
        chk("lat_seen", seen, 1);
        chk("stall_stable", unstable, 0);
        chk("stall_reqs", reqs, 2);
        chk("stall_fill", fill, 2);
        chk("stall_ovf", ovf, 0);

        // Stream 48 words with ready held high.
        ngot = 0;
        c32 = -1;
        k = 0;
        bus.rnd_ready = 1'b1;
        while (ngot < 48 && k < 400) begin
            if (bus.rnd_valid) begin
                got[ngot] = bus.rnd_data;
                ngot++;
                if (ngot == 32) c32 = k + 1;
            end
            k++;
            @(negedge clk);
        end
        bus.rnd_ready = 1'b0;
        chk("stream_count", ngot, 48);
        chk("no_gap_32", c32, 32);
        foreach (tbl[i]) begin
            chk($sformatf("tbl_word%0d", tbl[i].n), got[tbl[i].n], tbl[i].exp);
        end
        for (int i = 0; i < ngot; i++) begin
            logic [511:0] b;
            b = blkgen(i / 16);
            chk($sformatf("stream_w%0d", i), got[i], b[32*(i%16) +: 32]);
        end

        // Last word drained in the same cycle a block arrives at full.
        do_reset();
        inject(0);
        inject(1);
        chk("full_fill", fill, 2);
        take(15);
        chk("w15", bus.rnd_data, 32'hC0DE000F);
        bus.rnd_ready = 1'b1;
        bus.blk_valid = 1'b1;
        bus.blk_data = blkgen(2);
        @(negedge clk);
        bus.rnd_ready = 1'b0;
        bus.blk_valid = 1'b0;
        chk("drain_cap_fill", fill, 2);
        chk("drain_cap_ovf", ovf, 0);
        chk("drain_cap_data", bus.rnd_data, 32'hC0DE0100);
        take(16);
        chk("drain_cap_b2", bus.rnd_data, 32'hC0DE0200);

        // Block arriving at full with no drain is dropped.
        do_reset();
        inject(0);
        inject(1);
        inject(2);
        chk("ovf_set", ovf, 1);
        chk("ovf_fill", fill, 2);
        chk("ovf_data", bus.rnd_data, 32'hC0DE0000);
        take(16);
        chk("ovf_b1", bus.rnd_data, 32'hC0DE0100);
        take(16);
        chk("ovf_empty", fill, 0);
        chk("ovf_novalid", bus.rnd_valid, 0);
        chk("ovf_sticky", ovf, 1);

        // Reset in the middle of a block.
        do_reset();
        inject(0);
        take(7);
        chk("mid_w7", bus.rnd_data, 32'hC0DE0007);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", bus.rnd_valid, 0);
        chk("mid_rst_fill", fill, 0);
        chk("mid_rst_data", bus.rnd_data, 0);
        inject(1);
        chk("unsol_data", bus.rnd_data, 32'hC0DE0100);
        chk("unsol_fill", fill, 1);

        // Outstanding request completes after enable drops.
        do_reset();
        core_on = 1'b1;
        enable = 1'b1;
        r0 = reqs;
        k = 0;
        while (reqs == r0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        chk("en_req_seen", reqs, r0 + 1);
        repeat (40) @(negedge clk);
        chk("en_off_fill", fill, 1);
        take(16);
        repeat (30) @(negedge clk);
        chk("en_off_empty", fill, 0);
        chk("en_off_reqs", reqs, r0 + 1);

`ifdef RNG_REPEAT_CHECK_EN
        do_reset();
        inject(0);
        inject(0);
        chk("rep_fill", fill, 1);
        chk("rep_err", rep_err, 1);
        inject(1);
        chk("rep_next", fill, 2);
`endif

        chk("req_not_back2back", consec, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
